// File: rtl/bcd_stopwatch_n.sv
// Multi-digit BCD up/down stopwatch: prescaled run/pause, clamped preload, wrap limit, lap-freeze display.
// Latency: count->digits 1 cycle, wrap/running registered; no backpressure, inputs sampled every cycle.
module bcd_stopwatch_n #(
    parameter int DIGITS = 2,
    parameter int MAX    = 99,
    parameter int DIV    = 1
) (
    input  logic                  clk,
    input  logic                  rest_n,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  clr,
    input  logic                  up_dn,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    input  logic                  lap,
    output logic [4*DIGITS-1:0]   digits,
    output logic                  wrap,
    output logic                  running
);
    localparam int W  = 4 * DIGITS;
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

    function automatic logic [W-1:0] to_bcd(input int v);
        int r;
        r      = v;
        to_bcd = '0;
        for (int i = 0; i < DIGITS; i++) begin
            to_bcd[4*i +: 4] = 4'(r % 10);
            r = r / 10;
        end
    endfunction

    localparam logic [W-1:0]  MAX_BCD  = to_bcd(MAX);
    localparam logic [PW-1:0] PSC_LAST = PW'(DIV - 1);

    generate
        if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
            $error("bcd_stopwatch_n: DIGITS must be 1..8");
        end
        if (MAX < 0 || MAX >= 10**DIGITS) begin : g_bad_max
            $error("bcd_stopwatch_n: MAX must be below 10**DIGITS");
        end
        if (DIV < 1) begin : g_bad_div
            $error("bcd_stopwatch_n: DIV must be at least 1");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   count_q, count_d;
    logic [W-1:0]   digits_q, digits_d;
    logic [PW-1:0]  psc_q, psc_d;
    logic           wrap_q, wrap_d;
    logic           running_q;

    logic           tick;
    logic [W-1:0]   inc_v, dec_v, load_v;
    logic           carry, borrow;
    logic [3:0]     nib;

    assign tick = (state_q == RUN) && (psc_q == PSC_LAST);

    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (start && !stop) state_d = RUN;
                RUN:     if (stop)           state_d = PAUSE;
                PAUSE:   if (start && !stop) state_d = RUN;
                default:                     state_d = IDLE;
            endcase
        end
    end

    // Ripple BCD increment/decrement and saturating preload, one nibble at a time.
    always_comb begin
        inc_v  = count_q;
        dec_v  = count_q;
        load_v = '0;
        carry  = 1'b1;
        borrow = 1'b1;
        nib    = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (count_q[4*i +: 4] == 4'd9) begin
                    inc_v[4*i +: 4] = 4'd0;
                end else begin
                    inc_v[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
            if (borrow) begin
                if (count_q[4*i +: 4] == 4'd0) begin
                    dec_v[4*i +: 4] = 4'd9;
                end else begin
                    dec_v[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
                    borrow = 1'b0;
                end
            end
            nib = load_val[4*i +: 4];
            load_v[4*i +: 4] = (nib > 4'd9) ? 4'd9 : nib;
        end
        // Valid BCD orders the same as plain unsigned, so the clamp is a vector compare.
        if (load_v > MAX_BCD) load_v = MAX_BCD;
    end

    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        psc_d   = '0;
        if (clr) begin
            count_d = '0;
        end else begin
            if (load && state_q != RUN) begin
                count_d = load_v;
            end else if (tick) begin
                if (up_dn) begin
                    if (count_q == MAX_BCD) begin
                        count_d = '0;
                        wrap_d  = 1'b1;
                    end else begin
                        count_d = inc_v;
                    end
                end else begin
                    if (count_q == '0) begin
                        count_d = MAX_BCD;
                        wrap_d  = 1'b1;
                    end else begin
                        count_d = dec_v;
                    end
                end
            end
            if (state_q == RUN && state_d == RUN && !tick) psc_d = psc_q + PW'(1);
        end
        if (clr)       digits_d = '0;
        else if (lap)  digits_d = digits_q;
        else           digits_d = count_q;
    end

    always_ff @(posedge clk or negedge rest_n) begin
        if (!rest_n) begin
            state_q   <= IDLE;
            count_q   <= '0;
            digits_q  <= '0;
            psc_q     <= '0;
            wrap_q    <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            digits_q  <= digits_d;
            psc_q     <= psc_d;
            wrap_q    <= wrap_d;
            running_q <= (state_d == RUN);
        end
    end

    assign digits  = digits_q;
    assign wrap    = wrap_q;
    assign running = running_q;
endmodule

// File: tb/tb_bcd_stopwatch_n.sv
// Bench for bcd_stopwatch_n: integer reference model feeds an expectation queue, monitor compares each cycle.
module tb_bcd_stopwatch_n;
    localparam int DIGITS = 3;
    localparam int MAX    = 250;
    localparam int DIV    = 3;
    localparam int W      = 4 * DIGITS;

    logic           clk = 1'b0;
    logic           rest_n, start, stop, clr, up_dn, load, lap;
    logic [W-1:0]   load_val;
    logic [W-1:0]   digits;
    logic           wrap, running;

    always #5 clk = ~clk;

    bcd_stopwatch_n #(.DIGITS(DIGITS), .MAX(MAX), .DIV(DIV)) dut (
        .clk(clk), .rest_n(rest_n), .start(start), .stop(stop), .clr(clr),
        .up_dn(up_dn), .load(load), .load_val(load_val), .lap(lap),
        .digits(digits), .wrap(wrap), .running(running)
    );

    typedef struct {
        logic [W-1:0] dig;
        logic         wrp;
        logic         run;
    } exp_t;

    exp_t exp_q[$];
    int   chk_cnt  = 0;
    int   pass_cnt = 0;

    // Reference state: plain integers; state 0 = idle, 1 = run, 2 = pause.
    int m_cnt, m_psc, m_state, m_disp;
    logic cur_ud;

    function automatic logic [W-1:0] enc(input int v);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = 4'((v / (10**i)) % 10);
        return r;
    endfunction

    function automatic int load_value(input logic [W-1:0] lv);
        int v, d;
        v = 0;
        for (int i = 0; i < DIGITS; i++) begin
            d = int'(lv[4*i +: 4]);
            if (d > 9) d = 9;
            v = v + d * (10**i);
        end
        return (v > MAX) ? MAX : v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        chk_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    endtask

    task automatic model_reset();
        m_cnt = 0; m_psc = 0; m_state = 0; m_disp = 0;
    endtask

    task automatic step(input logic st, input logic sp, input logic cl, input logic ld,
                        input logic [W-1:0] lv, input logic lp);
        int   nstate, ncnt, npsc, ndisp;
        bit   tick, wr;
        exp_t e;
        @(negedge clk);
        start = st; stop = sp; clr = cl; load = ld; load_val = lv; lap = lp; up_dn = cur_ud;

        tick = (m_state == 1) && (m_psc == DIV - 1);
        if (cl)                     nstate = 0;
        else if (sp)                nstate = (m_state == 1) ? 2 : m_state;
        else if (st)                nstate = 1;
        else                        nstate = m_state;

        wr = 0;
        ncnt = m_cnt;
        if (cl) ncnt = 0;
        else if (ld && m_state != 1) ncnt = load_value(lv);
        else if (tick) begin
            if (cur_ud) begin
                if (m_cnt == MAX) begin ncnt = 0; wr = 1; end
                else ncnt = m_cnt + 1;
            end else begin
                if (m_cnt == 0) begin ncnt = MAX; wr = 1; end
                else ncnt = m_cnt - 1;
            end
        end

        npsc  = (!cl && m_state == 1 && nstate == 1 && !tick) ? m_psc + 1 : 0;
        ndisp = cl ? 0 : (lp ? m_disp : m_cnt);

        m_state = nstate; m_cnt = ncnt; m_psc = npsc; m_disp = ndisp;
        e.dig = enc(ndisp); e.wrp = wr; e.run = (nstate == 1);
        exp_q.push_back(e);
    endtask

    task automatic run_n(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    endtask

    // Outputs are compared 1 ns after every rising edge that follows a stimulus cycle.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("digits",  32'(digits),  32'(e.dig));
                check("wrap",    32'(wrap),    32'(e.wrp));
                check("running", 32'(running), 32'(e.run));
            end
        end
    end

    initial begin
        rest_n = 1'b0; start = 0; stop = 0; clr = 0; up_dn = 1; load = 0; load_val = '0; lap = 0;
        cur_ud = 1'b1;
        model_reset();
        #12;
        check("reset_digits",  32'(digits),  32'd0);
        check("reset_wrap",    32'(wrap),    32'd0);
        check("reset_running", 32'(running), 32'd0);
        @(negedge clk);
        rest_n = 1'b1;

        // Count up through 249, 250, 000 with a single wrap pulse.
        run_n(3);
        step(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        run_n((MAX + 2) * DIV + 2);

        // Pause mid-window, idle a while, resume: prescaler restarts from zero.
        step(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
        run_n(5);
        step(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        run_n(8);

        // Preloads in PAUSE: plain, clamped to MAX, bad-nibble saturation; then ignored in RUN.
        step(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 12'h123, 1'b0);
        run_n(2);
        step(1'b0, 1'b0, 1'b0, 1'b1, 12'h999, 1'b0);
        run_n(2);
        step(1'b0, 1'b0, 1'b0, 1'b1, 12'h0A5, 1'b0);
        run_n(2);
        step(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 12'h001, 1'b0);
        run_n(4);

        // Count down from 2 across the 0 -> MAX wrap, then start+stop together pauses.
        step(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 12'h002, 1'b0);
        cur_ud = 1'b0;
        step(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        run_n(5 * DIV);
        step(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0);
        run_n(6);
        cur_ud = 1'b1;

        // Lap freeze while running, release, then clear during lap.
        step(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
        run_n(3);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b1);
        run_n(3);

        // Asynchronous reset mid-run, between clock edges.
        step(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        run_n(7);
        @(posedge clk);
        #3;
        rest_n = 1'b0;
        #1;
        check("async_rst_digits",  32'(digits),  32'd0);
        check("async_rst_wrap",    32'(wrap),    32'd0);
        check("async_rst_running", 32'(running), 32'd0);
        start = 0; stop = 0; clr = 0; load = 0; lap = 0;
        model_reset();
        @(negedge clk);
        rest_n = 1'b1;
        run_n(5);

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            logic st, sp, cl, ld, lp;
            logic [W-1:0] lv;
            st = ($urandom % 8)  == 0;
            sp = ($urandom % 20) == 0;
            cl = ($urandom % 90) == 0;
            ld = ($urandom % 12) == 0;
            lp = ($urandom % 6)  == 0;
            lv = W'($urandom);
            if (($urandom % 40) == 0) cur_ud = ~cur_ud;
            step(st, sp, cl, ld, lv, lp);
        end

        @(posedge clk);
        #3;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
